// File: rtl/lsu_mc_if.sv
// Handshaked data-memory port between lsu_mc (master) and the memory (slave).
interface lsu_mc_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: lane steering, sign/zero extension, stall and misalign faults.
// Optional watchdog on the memory handshake when LSU_TIMEOUT_EN is defined.
module lsu_mc #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              fault,
    output logic              bus_err,
    lsu_mc_if.master          mem,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    localparam int NB = DATA_W / 8;
    localparam int L  = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

    typedef struct packed {
        logic              load;
        logic              store;
        logic [2:0]        funct3;
        logic [L-1:0]      off;
        logic [ADDR_W-1:0] waddr;
        logic [NB-1:0]     be;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state, state_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] rdata_q;
    logic              abort_q;
    logic              f3_ok, aligned, legal, to_hit;
    logic [NB-1:0]     size_mask;
    logic [DATA_W-1:0] lane, ext;
    logic              unused_ok;

    assign unused_ok = ^{ex_addr[DATA_W-1:ADDR_W+L], TIMEOUT_CYCLES[0]};

    // Decode legality of the presented access
    always_comb begin
        f3_ok = 1'b0;
        case (ex_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b011:                 f3_ok = (DATA_W == 64);
            3'b100, 3'b101:         f3_ok = ex_load;
            3'b110:                 f3_ok = ex_load && (DATA_W == 64);
            default:                f3_ok = 1'b0;
        endcase
        aligned   = 1'b1;
        size_mask = NB'(1);
        case (ex_funct3[1:0])
            2'd0: begin aligned = 1'b1;                size_mask = NB'(8'h01); end
            2'd1: begin aligned = ~ex_addr[0];         size_mask = NB'(8'h03); end
            2'd2: begin aligned = (ex_addr[1:0] == 0); size_mask = NB'(8'h0F); end
            default: begin aligned = (ex_addr[2:0] == 0); size_mask = NB'(8'hFF); end
        endcase
        legal = f3_ok && aligned && (ex_load ^ ex_store);
    end

    always_comb begin
        req_d.load   = ex_load;
        req_d.store  = ex_store;
        req_d.funct3 = ex_funct3;
        req_d.off    = ex_addr[L-1:0];
        req_d.waddr  = ex_addr[ADDR_W+L-1:L];
        req_d.be     = size_mask << ex_addr[L-1:0];
        req_d.wdata  = ex_wdata << {ex_addr[L-1:0], 3'b000};
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;

    // Counts REQ cycles that ended without an ack; restarts on every REQ entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            to_cnt <= '0;
        else if (state != REQ || mem.mem_ack) to_cnt <= '0;
        else                                  to_cnt <= to_cnt + CW'(1);
    end
    assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d     = state;
        stall       = 1'b0;
        wb_valid    = 1'b0;
        fault       = 1'b0;
        bus_err     = 1'b0;
        wr          = 1'b0;
        rd          = 1'b0;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        case (state)
            IDLE: begin
                stall = ex_valid;
                if (ex_valid) state_d = legal ? REQ : FAULT;
            end
            REQ: begin
                stall       = ex_valid;
                mem.mem_req = 1'b1;
                mem.mem_we  = req_q.store;
                if (mem.mem_ack) state_d = DONE;
                else if (to_hit) state_d = FAULT;
            end
            DONE: begin
                wb_valid = req_q.load;
                rd       = req_q.load;
                wr       = req_q.store;
                state_d  = IDLE;
            end
            default: begin
                fault   = ~abort_q;
                bus_err = abort_q;
                state_d = IDLE;
            end
        endcase
        // Reset clears state asynchronously; keep the EX-driven stall quiet too
        if (reset) stall = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= '0;
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            if (state == IDLE && ex_valid && legal) req_q <= req_d;
            if (state == REQ && mem.mem_ack)        rdata_q <= mem.mem_rdata;
            abort_q <= (state == REQ) && !mem.mem_ack && to_hit;
        end
    end

    assign mem.mem_addr  = req_q.waddr;
    assign mem.mem_wdata = req_q.wdata;
    assign mem.mem_be    = req_q.be;

    always_comb begin
        lane = rdata_q >> {req_q.off, 3'b000};
        case (req_q.funct3)
            3'b000:  ext = DATA_W'($signed(lane[7:0]));
            3'b001:  ext = DATA_W'($signed(lane[15:0]));
            3'b010:  ext = DATA_W'($signed(lane[31:0]));
            3'b100:  ext = DATA_W'(lane[7:0]);
            3'b101:  ext = DATA_W'(lane[15:0]);
            3'b110:  ext = DATA_W'(lane[31:0]);
            default: ext = lane;
        endcase
    end

    assign wb_data = wb_valid ? ext : '0;
    assign addr    = (state == DONE) ? req_q.waddr : '0;
    assign wr_data = wr ? req_q.wdata : '0;
    assign rd_data = rd ? rdata_q : '0;
endmodule

// File: tb/tb_lsu_mc.sv
// Bench for lsu_mc: vector table with a pulse scoreboard, plus reset and watchdog sequences.
module tb_lsu_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        stall, wb_valid, fault, bus_err, wr, rd;
    logic [31:0] wb_data, wr_data, rd_data;
    logic [8:0]  addr;

    lsu_mc_if #(.DATA_W(32), .ADDR_W(9)) mem ();

    lsu_mc #(.DATA_W(32), .ADDR_W(9), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
        .fault(fault), .bus_err(bus_err), .mem(mem),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          waits;
        bit          e_fault;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [8:0]  e_maddr;
    } vec_t;

    // kind = {wb_valid, fault, bus_err, wr, rd}
    typedef struct {
        logic [4:0]  kind;
        logic [31:0] data;
        logic [8:0]  maddr;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    int          req_cycles = 0, wcnt = 0;
    int          cur_waits = 0;
    logic [31:0] cur_rdata = 0, cur_wd = 0;
    logic [3:0]  cur_be = 0;
    logic [8:0]  cur_maddr = 0;
    bit          cur_we = 0, hold_ack = 0, force_ack = 0;
    vec_t        vecs[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Memory model: acks after cur_waits wait cycles and checks the request it acks
    always @(negedge clk) begin
        logic [31:0] m;
        if (mem.mem_req) begin
            req_cycles++;
            if (!hold_ack && wcnt == cur_waits) begin
                mem.mem_ack   = 1'b1;
                mem.mem_rdata = cur_rdata;
                wcnt = 0;
                for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{cur_be[i]}};
                check("mem_addr", 64'(mem.mem_addr), 64'(cur_maddr));
                check("mem_be", 64'(mem.mem_be), 64'(cur_be));
                check("mem_we", 64'(mem.mem_we), 64'(cur_we));
                if (cur_we) check("mem_wdata", 64'(mem.mem_wdata & m), 64'(cur_wd & m));
            end else begin
                mem.mem_ack   = force_ack;
                mem.mem_rdata = $urandom;
                wcnt++;
            end
        end else begin
            mem.mem_ack   = force_ack;
            mem.mem_rdata = $urandom;
            wcnt = 0;
        end
    end

    // Scoreboard: every result pulse must match the oldest pending expectation
    always @(negedge clk) begin
        logic [4:0] kind;
        exp_t e;
        if (!reset) begin
            kind = {wb_valid, fault, bus_err, wr, rd};
            if (kind != 5'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 64'(kind), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", 64'(kind), 64'(e.kind));
                    if (e.kind[4]) check("wb_data", 64'(wb_data), 64'(e.data));
                    if (wr || rd) check("trace_addr", 64'(addr), 64'(e.maddr));
                end
            end
        end
    end

    task automatic wait_release(output int n);
        bit done = 0;
        n = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1;
        end
        if (!done) check("stall_timeout", 64'(1), 64'(0));
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        int   n, base;
        @(posedge clk); #1;
        base      = req_cycles;
        cur_waits = v.waits;
        cur_rdata = v.rdat;
        cur_be    = v.e_be;
        cur_wd    = v.e_wd;
        cur_we    = v.st;
        cur_maddr = v.e_maddr;
        e.kind    = v.e_fault ? 5'b01000 : (v.ld ? 5'b10001 : 5'b00010);
        e.data    = v.e_data;
        e.maddr   = v.e_maddr;
        sb.push_back(e);
        ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st;
        ex_funct3 = v.f3; ex_addr = v.a; ex_wdata = v.wd;
        wait_release(n);
        check("stall_cycles", 64'(n), 64'(v.e_fault ? 1 : 2 + v.waits));
        check("req_cycles", 64'(req_cycles - base), 64'(v.e_fault ? 0 : v.waits + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, base;
        vecs[0]  = '{1, 0, 3'b010, 32'h10,  32'h0,      32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0,      9'd4};
        vecs[1]  = '{1, 0, 3'b000, 32'h13,  32'h0,      32'h80FFFFFF, 0, 0, 32'hFFFFFF80, 4'b1000, 32'h0,      9'd4};
        vecs[2]  = '{1, 0, 3'b100, 32'h13,  32'h0,      32'h80FFFFFF, 1, 0, 32'h00000080, 4'b1000, 32'h0,      9'd4};
        vecs[3]  = '{0, 1, 3'b001, 32'h06,  32'h0000ABCD, 32'h0,      3, 0, 32'h0,        4'b1100, 32'hABCD0000, 9'd1};
        vecs[4]  = '{1, 0, 3'b001, 32'h02,  32'h0,      32'h80011234, 1, 0, 32'hFFFF8001, 4'b1100, 32'h0,      9'd0};
        vecs[5]  = '{1, 0, 3'b101, 32'h02,  32'h0,      32'h80011234, 0, 0, 32'h00008001, 4'b1100, 32'h0,      9'd0};
        vecs[6]  = '{0, 1, 3'b000, 32'h05,  32'h000000A5, 32'h0,      0, 0, 32'h0,        4'b0010, 32'h0000A500, 9'd1};
        vecs[7]  = '{0, 1, 3'b010, 32'h7FC, 32'h12345678, 32'h0,      2, 0, 32'h0,        4'b1111, 32'h12345678, 9'h1FF};
        vecs[8]  = '{1, 0, 3'b000, 32'h00,  32'h0,      32'h0000007F, 0, 0, 32'h0000007F, 4'b0001, 32'h0,      9'd0};
        vecs[9]  = '{1, 0, 3'b010, 32'h02,  32'h0,      32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,      9'd0};
        vecs[10] = '{1, 1, 3'b010, 32'h10,  32'h0,      32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,      9'd0};
        vecs[11] = '{1, 0, 3'b001, 32'h01,  32'h0,      32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,      9'd0};
        vecs[12] = '{1, 0, 3'b011, 32'h08,  32'h0,      32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,      9'd0};
        vecs[13] = '{0, 1, 3'b100, 32'h04,  32'h11,     32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,      9'd0};
        vecs[14] = '{0, 0, 3'b010, 32'h00,  32'h0,      32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,      9'd0};
        vecs[15] = '{1, 0, 3'b010, 32'h7FC, 32'h0,      32'h01234567, 0, 0, 32'h01234567, 4'b1111, 32'h0,      9'h1FF};

        reset = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_funct3 = 3'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({stall, wb_valid, fault, bus_err, wr, rd, mem.mem_req, mem.mem_we}), 64'(0));
        check("reset_bus", 64'({mem.mem_addr, mem.mem_be, mem.mem_wdata}), 64'(0));
        check("reset_trace", 64'({addr, wb_data}), 64'(0));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_ctrl", 64'({stall, mem.mem_req, wb_valid, fault}), 64'(0));

        foreach (vecs[i]) run(vecs[i]);
        @(posedge clk); #1 ex_valid = 1'b0;

        // Reset in the middle of an unacknowledged request
        @(posedge clk); #1;
        hold_ack = 1'b1;
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h20;
`ifdef LSU_TIMEOUT_EN
        repeat (5) @(negedge clk);
`else
        repeat (20) @(negedge clk);
`endif
        check("req_wait", 64'({stall, mem.mem_req, bus_err}), 64'(3'b110));
        #2 reset = 1'b1;
        #1 check("midreq_reset", 64'({stall, mem.mem_req, mem.mem_we, mem.mem_be, mem.mem_addr, wb_valid, fault, rd, wr}), 64'(0));
        ex_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0; hold_ack = 1'b0; force_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("stray_ack", 64'({mem.mem_req, stall, wb_valid, rd}), 64'(0));
        force_ack = 1'b0;
        run(vecs[0]);
        @(posedge clk); #1 ex_valid = 1'b0;

`ifdef LSU_TIMEOUT_EN
        begin
            exp_t e;
            @(posedge clk); #1;
            hold_ack = 1'b1;
            base = req_cycles;
            e.kind = 5'b00100; e.data = 32'h0; e.maddr = 9'd0;
            sb.push_back(e);
            ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h40;
            wait_release(n);
            check("to_stall_cycles", 64'(n), 64'(17));
            check("to_req_cycles", 64'(req_cycles - base), 64'(16));
            check("to_req_low", 64'({mem.mem_req, wb_valid}), 64'(0));
            @(posedge clk); #1 ex_valid = 1'b0; hold_ack = 1'b0;
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_mc.md
# lsu_mc

Parametrised multi-cycle load/store unit placed between the datapath's execute stage and a handshaked data memory. It replaces a single-cycle direct memory hookup with byte/halfword/word (and doubleword at DATA_W=64) accesses, lane steering and sign/zero extension. It adds a request/acknowledge memory port, datapath stall generation and misalignment faulting. It also drives the same one-cycle memory trace signals (wr, rd, addr, wr_data, rd_data) the core exports for the testbench.

## Interface
- DATA_W, 32, datapath/memory word width; legal values 32 or 64
- ADDR_W, 9, memory word-address width
- TIMEOUT_CYCLES, 16, watchdog limit; used only with LSU_TIMEOUT_EN

Ports:
- clk  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- ex_valid  in  1  EX stage presents an access; inputs held stable while stall=1
- ex_load / ex_store  in  1 each  access kind
- ex_funct3  in  3  000 B, 001 H, 010 W, 011 D (64 only), 100 BU, 101 HU, 110 WU (64 only)
- ex_addr  in  DATA_W  byte address
- ex_wdata  in  DATA_W  store data, right-aligned
- stall  out  1  freeze pipeline
- wb_valid  out  1  load result valid (one-cycle pulse)
- wb_data  out  DATA_W  extended load result
- fault  out  1  one-cycle pulse: misaligned, illegal funct3, or load+store both high
- bus_err  out  1  one-cycle pulse on watchdog abort
- mem_req, mem_we  out  1  request / write enable
- mem_addr  out  ADDR_W  word address = ex_addr[ADDR_W+L-1:L], L=log2(DATA_W/8)
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_be  out  DATA_W/8  byte enables
- mem_ack  in  1  completion; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  read word
- wr, rd  out  1  trace pulses at completion
- addr  out  ADDR_W  trace word address
- wr_data, rd_data  out  DATA_W  trace store data / raw read word

## Operation
- States: IDLE, REQ, DONE, FAULT.
- IDLE, ex_valid=1: if illegal (misaligned, funct3 invalid for width/kind, load&&store, neither) -> FAULT; else latch addr/be/wdata/kind -> REQ.
- Alignment: H needs addr[0]=0; W addr[1:0]=0; D addr[2:0]=0; B always aligned.
- REQ: mem_req=1, mem_we=store, all mem_* held constant until mem_ack=1; on ack capture mem_rdata -> DONE.
- DONE: load: wb_valid=1, wb_data=selected lanes sign- (B/H/W) or zero- (BU/HU/WU) extended; store: wb_valid=0. Trace pulse (rd or wr). -> IDLE.
- FAULT: fault=1, no memory access, no trace -> IDLE.
- stall = ex_valid && state∉{DONE, FAULT}; deasserts for exactly the completion cycle.
- Store: mem_be = size mask << byte offset; mem_wdata = ex_wdata << (8*offset); unused lanes don't-care.
- mem_ack outside REQ is ignored.

## Timing
- Minimum access: accept cycle (IDLE) + ≥1 REQ cycle + DONE = 3 cycles; each extra ack wait adds 1.
- mem_req registered; rises the cycle after acceptance; falls the cycle after ack.
- Back-to-back: next access accepted in the IDLE cycle following DONE.
- Reset (any state, including mid-REQ): state IDLE; stall, wb_valid, wb_data, fault, bus_err, mem_req, mem_we, mem_addr, mem_wdata, mem_be, wr, rd, addr, wr_data, rd_data all 0; outstanding request dropped.

## Configuration
- LSU_TIMEOUT_EN defined: counter clears on REQ entry, increments each REQ cycle without ack; on reaching TIMEOUT_CYCLES, drop mem_req, pulse bus_err in a FAULT-like cycle (fault=0), return IDLE, no wb_valid.
- Undefined: no counter; REQ waits indefinitely; bus_err tied 0.

## Test plan
- LW addr 0x10, ack in first REQ cycle, rdata 0xDEADBEEF -> mem_addr=4, be=1111, wb_valid at cycle 3 with 0xDEADBEEF, rd pulse, stall high cycles 1-2.
- LB addr 0x13 rdata 0x80FF_FFFF -> wb_data 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x06 wdata 0x0000ABCD, ack after 3 wait cycles -> be=1100, mem_wdata[31:16]=0xABCD, mem_req held 4 cycles, wr pulse, no wb_valid.
- LW addr 0x02 -> fault pulse cycle 2, mem_req never asserted; ex_load=ex_store=1 -> same.
- Reset asserted mid-REQ -> all outputs 0 immediately; later stray mem_ack ignored, next LW completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> bus_err pulse after 16 REQ cycles, mem_req low, stall released.
